// File: rtl/aes_pkg.sv
// Shared AES decrypt-side definitions: GF(2^8) constants, the InvMixColumns
// coefficient row, the sequencer state encoding and constant-multiply helpers.
package aes_pkg;

  localparam logic [7:0]  GF_POLY      = 8'h1B;
  localparam logic [31:0] INV_MIX_COEF = {8'h0E, 8'h0B, 8'h0D, 8'h09};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } inv_mix_state_t;

  // Multiply by x modulo x^8+x^4+x^3+x+1; the x^8 term folds back as 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // Constant multiply as a sum of the xtime chain a, x2, x4, x8, ...
  // selected by the set bits of coef.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] coef);
    logic [7:0] acc;
    logic [7:0] pow;
    acc = 8'h00;
    pow = a;
    for (int i = 0; i < 8; i++) begin
      if (coef[i]) acc ^= pow;
      pow = xtime(pow);
    end
    return acc;
  endfunction

  // Coefficient at position idx of the unrotated row {0e,0b,0d,09}.
  function automatic logic [7:0] inv_mix_coef_at(input int idx);
    return INV_MIX_COEF[31-8*idx -: 8];
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// One-column InvMixColumns: row r uses the coefficient row rotated right by r.
// Byte 0 of the column is the most significant byte.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  always_comb begin
    // NOTE: default assignment first so no path leaves mixed unassigned (no latch).
    mixed = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        mixed[31-8*r -: 8] ^= gf_mul_const(col[31-8*k -: 8], inv_mix_coef_at((k - r + 4) % 4));
      end
    end
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: accepts one 128-bit state, transforms NUM_LANES
// columns per clock in place, then holds the result until the consumer takes it.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int NUM_LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4) begin : g_bad_lanes
    $error("inv_mix_columns_seq: NUM_LANES must be 1, 2 or 4");
  end

  // With four lanes the step wraps to 0 and the first group is also the last.
  localparam logic [1:0] LANE_STEP = 2'(NUM_LANES);
  localparam logic [1:0] LAST_CNT  = 2'(4 - NUM_LANES);

  inv_mix_state_t state_q;
  logic [1:0]     cnt_q;
  logic [127:0]   work_q;
  logic [127:0]   work_next;

  logic [NUM_LANES-1:0][1:0]  col_idx;
  logic [NUM_LANES-1:0][31:0] lane_in;
  logic [NUM_LANES-1:0][31:0] lane_out;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign col_idx[l] = cnt_q + 2'(l);
    assign lane_in[l] = work_q[32*(3 - int'(col_idx[l])) +: 32];

    inv_mix_column u_col (
      .col   (lane_in[l]),
      .mixed (lane_out[l])
    );
  end

  always_comb begin
    work_next = work_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      work_next[32*(3 - int'(col_idx[l])) +: 32] = lane_out[l];
    end
  end

  assign in_ready  = (state_q == IDLE);
  // The work register is transformed in place and doubles as the output register.
  assign out_state = work_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the 128-bit work register is reset too, so a transaction cut
      // short by reset never leaves a visible partial result on out_state.
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      work_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= in_state;
            cnt_q   <= 2'd0;
            state_q <= CALC;
          end
        end
        CALC: begin
          work_q <= work_next;
          cnt_q  <= cnt_q + LANE_STEP;
          if (cnt_q == LAST_CNT) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: one instance per legal lane count
// (index 0 -> 1 lane, 1 -> 2 lanes, 2 -> 4 lanes) sharing clock and reset.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [127:0] VEC1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC2_IN  = 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_01010101;
  localparam logic [127:0] VEC2_OUT = 128'hd4d4d4d5_2d26314c_c6c6c6c6_01010101;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq #(.NUM_LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  // Encrypt-side MixColumns model, used to build round-trip vectors.
  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
      r[103-32*c -: 8] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
    end
    return r;
  endfunction

  // Handshake one state into instance g, then count edges until out_valid.
  task automatic run_txn(input int g, input logic [127:0] st,
                         output logic [127:0] res, output int lat, output bit timeout);
    @(negedge clk);
    in_state[g] = st;
    in_valid[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[g] = 1'b0;
    lat = 0;
    timeout = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid[g]) begin
        timeout = 1'b0;
        break;
      end
    end
    res = out_state[g];
  endtask

  task automatic release_out(input int g);
    out_ready[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[g] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int g = 0; g < 3; g++) begin
      tests_run++;
      if (in_ready[g] !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_in_ready[%0d]: got %b expected 1", g, in_ready[g]);
      end
      tests_run++;
      if (out_valid[g] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_out_valid[%0d]: got %b expected 0", g, out_valid[g]);
      end
      tests_run++;
      if (out_state[g] !== 128'h0) begin
        tests_failed++;
        $display("FAIL reset_out_state[%0d]: got %h expected 0", g, out_state[g]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vector(input int g, input logic [127:0] st,
                             input logic [127:0] exp, input int exp_lat, input string name);
    logic [127:0] res;
    int lat;
    bit to;
    run_txn(g, st, res, lat, to);
    tests_run++;
    if (to || lat != exp_lat) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d (timeout=%0b) expected %0d", name, lat, to, exp_lat);
    end
    tests_run++;
    if (res !== exp) begin
      tests_failed++;
      $display("FAIL %s_result: got %h expected %h", name, res, exp);
    end
    release_out(g);
    tests_run++;
    if (in_ready[g] !== 1'b1 || out_valid[g] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_back_to_idle: got in_ready=%b out_valid=%b expected 1/0",
               name, in_ready[g], out_valid[g]);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] res;
    logic [127:0] res2;
    int lat;
    bit to;
    run_txn(0, VEC1_IN, res, lat, to);
    tests_run++;
    if (to || res !== VEC1_OUT) begin
      tests_failed++;
      $display("FAIL bp_first_result: got %h (timeout=%0b) expected %h", res, to, VEC1_OUT);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_state[0] = VEC2_IN;
        in_valid[0] = 1'b1;
      end else if (i == 4) begin
        in_valid[0] = 1'b0;
      end else if (i == 6) begin
        in_valid[0] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (out_state[0] !== VEC1_OUT || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got state=%h in_ready=%b out_valid=%b expected %h/0/1",
                 i, out_state[0], in_ready[0], out_valid[0], VEC1_OUT);
      end
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
    tests_run++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release_idle: got in_ready=%b out_valid=%b expected 1/0",
               in_ready[0], out_valid[0]);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    tests_run++;
    if (in_ready[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_queued_accept: got in_ready=%b expected 0", in_ready[0]);
    end
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid[0]) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    res2 = out_state[0];
    tests_run++;
    if (to || res2 !== VEC2_OUT) begin
      tests_failed++;
      $display("FAIL bp_queued_result: got %h (timeout=%0b) expected %h", res2, to, VEC2_OUT);
    end
    release_out(0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] x [8];
    int accept_cyc [8];
    int sent = 0;
    int got = 0;
    for (int i = 0; i < 8; i++) x[i] = {$urandom, $urandom, $urandom, $urandom};
    out_ready[1] = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      @(negedge clk);
      if (out_valid[1]) begin
        tests_run++;
        if (out_state[1] !== x[got]) begin
          tests_failed++;
          $display("FAIL b2b_result[%0d]: got %h expected %h", got, out_state[1], x[got]);
        end
        got++;
      end
      if (in_ready[1] && sent < 8) begin
        in_state[1] = fwd_mix(x[sent]);
        in_valid[1] = 1'b1;
        accept_cyc[sent] = cyc;
        sent++;
      end else if (sent == 8) begin
        in_valid[1] = 1'b0;
      end
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b0;
    tests_run++;
    if (got != 8) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d results expected 8", got);
    end
    for (int i = 1; i < sent; i++) begin
      tests_run++;
      if (accept_cyc[i] - accept_cyc[i-1] != 4) begin
        tests_failed++;
        $display("FAIL b2b_interval[%0d]: got %0d cycles expected 4",
                 i, accept_cyc[i] - accept_cyc[i-1]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    in_state[0] = VEC1_IN;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid[0] !== 1'b0 || out_state[0] !== 128'h0) begin
      tests_failed++;
      $display("FAIL midcalc_reset: got out_valid=%b state=%h expected 0/0",
               out_valid[0], out_state[0]);
    end
    tests_run++;
    if (in_ready[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midcalc_in_ready: got %b expected 1", in_ready[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_vector(0, VEC1_IN, VEC1_OUT, 4, "after_reset");
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      in_valid[g]  = 1'b0;
      in_state[g]  = '0;
      out_ready[g] = 1'b0;
    end
    test_reset();
    test_vector(0, VEC1_IN, VEC1_OUT, 4, "lanes1_vec1");
    test_vector(2, VEC2_IN, VEC2_OUT, 1, "lanes4_vec2");
    test_vector(1, VEC1_IN, VEC1_OUT, 2, "lanes2_vec1");
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    test_vector(2, 128'h0, 128'h0, 1, "zero_state");
    test_vector(1, {16{8'hff}}, {16{8'hff}}, 2, "ones_state");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
